// File: rtl/comparador_serial_cascata.sv
// Nibble-serial magnitude comparator, LSB nibble first.
// Drives 7485-style cascade outputs from registers only.
module comparador_serial_cascata #(
  parameter int N_DIGITOS = 4,
  localparam int W = $clog2(N_DIGITOS)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         iniciar,
  input  logic         digito_valido,
  input  logic [3:0]   digito_A,
  input  logic [3:0]   digito_B,
  output logic         ocupado,
  output logic         fim,
  output logic [W-1:0] contagem_digitos,
  output logic         A_maior_que_B,
  output logic         A_menor_que_B,
  output logic         A_igual_a_B
);

  typedef enum logic [1:0] {
    OCIOSO,
    COMPARANDO,
    CONCLUIDO
  } estado_t;

  // result vector is {maior, menor, igual}
  localparam logic [2:0] RES_NEUTRO = 3'b001;
  localparam logic [2:0] RES_MAIOR  = 3'b100;
  localparam logic [2:0] RES_MENOR  = 3'b010;

  localparam logic [W-1:0] ULTIMO = W'(N_DIGITOS - 1);
  localparam logic [W-1:0] UM     = W'(1);

  estado_t      estado_q;
  estado_t      estado_d;
  logic [W-1:0] cont_q;
  logic [W-1:0] cont_d;
  logic [2:0]   res_q;
  logic [2:0]   res_d;
  logic         ocupado_q;
  logic         ocupado_d;
  logic         fim_q;
  logic         fim_d;

  logic ultimo;

  assign ultimo = (cont_q == ULTIMO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO: begin
        if (iniciar) estado_d = COMPARANDO;
      end
      COMPARANDO: begin
        if (digito_valido && ultimo) estado_d = CONCLUIDO;
      end
      CONCLUIDO: begin
        estado_d = iniciar ? COMPARANDO : OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // A nibble that differs overrides everything less significant.
  always_comb begin
    res_d     = res_q;
    cont_d    = cont_q;
    ocupado_d = (estado_d == COMPARANDO);
    fim_d     = (estado_d == CONCLUIDO);
    unique case (estado_q)
      COMPARANDO: begin
        if (digito_valido) begin
          if (digito_A > digito_B) begin
            res_d = RES_MAIOR;
          end else if (digito_A < digito_B) begin
            res_d = RES_MENOR;
          end
          cont_d = ultimo ? '0 : cont_q + UM;
        end
      end
      OCIOSO, CONCLUIDO: begin
        if (iniciar) begin
          res_d  = RES_NEUTRO;
          cont_d = '0;
        end
      end
      default: begin
        res_d  = RES_NEUTRO;
        cont_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_q    <= '0;
      res_q     <= RES_NEUTRO;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      cont_q    <= cont_d;
      res_q     <= res_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  assign ocupado          = ocupado_q;
  assign fim              = fim_q;
  assign contagem_digitos = cont_q;
  assign A_maior_que_B    = res_q[2];
  assign A_menor_que_B    = res_q[1];
  assign A_igual_a_B      = res_q[0];

endmodule

// File: tb/tb_comparador_serial_cascata.sv
// Bench for comparador_serial_cascata: directed words plus
// random words with gaps, against a whole-number reference.
module tb_comparador_serial_cascata;

  localparam int N = 4;
  localparam int W = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         iniciar;
  logic         digito_valido;
  logic [3:0]   digito_A;
  logic [3:0]   digito_B;
  logic         ocupado;
  logic         fim;
  logic [W-1:0] contagem_digitos;
  logic         A_maior_que_B;
  logic         A_menor_que_B;
  logic         A_igual_a_B;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  comparador_serial_cascata #(.N_DIGITOS(N)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .iniciar          (iniciar),
    .digito_valido    (digito_valido),
    .digito_A         (digito_A),
    .digito_B         (digito_B),
    .ocupado          (ocupado),
    .fim              (fim),
    .contagem_digitos (contagem_digitos),
    .A_maior_que_B    (A_maior_que_B),
    .A_menor_que_B    (A_menor_que_B),
    .A_igual_a_B      (A_igual_a_B)
  );

  // {ocupado, fim, contagem, maior, menor, igual}
  function automatic logic [6:0] obs();
    return {ocupado, fim, contagem_digitos,
            A_maior_que_B, A_menor_que_B, A_igual_a_B};
  endfunction

  function automatic logic [6:0] expv(input logic oc, input logic f,
                                      input int k, input logic [2:0] r);
    return {oc, f, 2'(k), r};
  endfunction

  // Compare the low k nibbles of both words as plain numbers.
  function automatic logic [2:0] ref_cmp(input int unsigned a,
                                         input int unsigned b,
                                         input int k);
    int unsigned m;
    m = (32'h1 << (4 * k)) - 1;
    if ((a & m) > (b & m)) return 3'b100;
    if ((a & m) < (b & m)) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [3:0] nib_of(input int unsigned w, input int i);
    return 4'((w >> (4 * i)) & 32'hF);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic nib(input logic [3:0] a, input logic [3:0] b);
    digito_valido = 1'b1;
    digito_A = a;
    digito_B = b;
    tick();
    digito_valido = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (obs() !== expv(0, 0, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs(), expv(0, 0, 0, 3'b001));
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_equal();
    int unsigned a = 32'h1234;
    start();
    n_checks++;
    if (obs() !== expv(1, 0, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL equal_start: got %b want %b", obs(), expv(1, 0, 0, 3'b001));
    end
    for (int i = 0; i < N; i++) nib(nib_of(a, i), nib_of(a, i));
    n_checks++;
    if (obs() !== expv(0, 1, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL equal_fim: got %b want %b", obs(), expv(0, 1, 0, 3'b001));
    end
    tick();
    n_checks++;
    if (obs() !== expv(0, 0, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL equal_idle: got %b want %b", obs(), expv(0, 0, 0, 3'b001));
    end
  endtask

  task automatic test_override();
    int unsigned a = 32'h2000;
    int unsigned b = 32'h1FFF;
    start();
    nib(nib_of(a, 0), nib_of(b, 0));
    n_checks++;
    if (obs() !== expv(1, 0, 1, 3'b010)) begin
      n_fail++;
      $display("FAIL override_n0: got %b want %b", obs(), expv(1, 0, 1, 3'b010));
    end
    for (int i = 1; i < N; i++) nib(nib_of(a, i), nib_of(b, i));
    n_checks++;
    if (obs() !== expv(0, 1, 0, 3'b100)) begin
      n_fail++;
      $display("FAIL override_fim: got %b want %b", obs(), expv(0, 1, 0, 3'b100));
    end
    tick();
  endtask

  task automatic test_gaps();
    int unsigned a = 32'h0100;
    int unsigned b = 32'h0101;
    start();
    for (int i = 0; i < N; i++) begin
      nib(nib_of(a, i), nib_of(b, i));
      if (i < N - 1) begin
        digito_A = 4'hF;
        digito_B = 4'h0;
        repeat (3) tick();
        n_checks++;
        if (obs() !== expv(1, 0, i + 1, 3'b010)) begin
          n_fail++;
          $display("FAIL gap_%0d: got %b want %b", i, obs(),
                   expv(1, 0, i + 1, 3'b010));
        end
      end
    end
    n_checks++;
    if (obs() !== expv(0, 1, 0, 3'b010)) begin
      n_fail++;
      $display("FAIL gap_fim: got %b want %b", obs(), expv(0, 1, 0, 3'b010));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int unsigned a = 32'h0005;
    int unsigned b = 32'h0009;
    start();
    nib(4'h3, 4'h3);
    nib(4'hF, 4'h0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== expv(0, 0, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL reset_mid: got %b want %b", obs(), expv(0, 0, 0, 3'b001));
    end
    tick();
    reset_n = 1'b1;
    tick();
    start();
    for (int i = 0; i < N; i++) nib(nib_of(a, i), nib_of(b, i));
    n_checks++;
    if (obs() !== expv(0, 1, 0, 3'b010)) begin
      n_fail++;
      $display("FAIL reset_clean: got %b want %b", obs(), expv(0, 1, 0, 3'b010));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned a = 32'h9000;
    int unsigned b = 32'h1000;
    start();
    nib(nib_of(a, 0), nib_of(b, 0));
    iniciar = 1'b1;
    nib(nib_of(a, 1), nib_of(b, 1));
    iniciar = 1'b0;
    n_checks++;
    if (obs() !== expv(1, 0, 2, 3'b001)) begin
      n_fail++;
      $display("FAIL ini_mid: got %b want %b", obs(), expv(1, 0, 2, 3'b001));
    end
    for (int i = 2; i < N; i++) nib(nib_of(a, i), nib_of(b, i));
    n_checks++;
    if (obs() !== expv(0, 1, 0, 3'b100)) begin
      n_fail++;
      $display("FAIL b2b_fim: got %b want %b", obs(), expv(0, 1, 0, 3'b100));
    end
    start();
    n_checks++;
    if (obs() !== expv(1, 0, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL restart: got %b want %b", obs(), expv(1, 0, 0, 3'b001));
    end
    a = 32'h0003;
    b = 32'h0004;
    for (int i = 0; i < N; i++) nib(nib_of(a, i), nib_of(b, i));
    tick();
    nib(4'hF, 4'h0);
    nib(4'hE, 4'h1);
    tick();
    n_checks++;
    if (obs() !== expv(0, 0, 0, 3'b010)) begin
      n_fail++;
      $display("FAIL idle_hold: got %b want %b", obs(), expv(0, 0, 0, 3'b010));
    end
    iniciar = 1'b1;
    nib(4'hF, 4'h0);
    iniciar = 1'b0;
    n_checks++;
    if (obs() !== expv(1, 0, 0, 3'b001)) begin
      n_fail++;
      $display("FAIL start_drop: got %b want %b", obs(), expv(1, 0, 0, 3'b001));
    end
    for (int i = 0; i < N; i++) nib(4'h7, 4'h7);
    tick();
  endtask

  task automatic test_random();
    int unsigned a;
    int unsigned b;
    logic [2:0] r;
    for (int w = 0; w < 30; w++) begin
      a = $urandom_range(0, 16'hFFFF);
      b = a;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1)
          b = (b & ~(32'hF << (4 * i))) | ($urandom_range(0, 15) << (4 * i));
      start();
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 2)) begin
          digito_A = 4'($urandom_range(0, 15));
          digito_B = 4'($urandom_range(0, 15));
          iniciar = 1'($urandom_range(0, 1));
          tick();
        end
        iniciar = 1'b0;
        nib(nib_of(a, i), nib_of(b, i));
        r = ref_cmp(a, b, i + 1);
        n_checks++;
        if (obs() !== expv(i != N - 1, i == N - 1, (i + 1) % N, r)) begin
          n_fail++;
          $display("FAIL rand w%0d n%0d A=%h B=%h: got %b want %b", w, i,
                   a, b, obs(), expv(i != N - 1, i == N - 1, (i + 1) % N, r));
        end
      end
      tick();
      n_checks++;
      if (obs() !== expv(0, 0, 0, ref_cmp(a, b, N))) begin
        n_fail++;
        $display("FAIL rand_hold w%0d: got %b want %b", w, obs(),
                 expv(0, 0, 0, ref_cmp(a, b, N)));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    iniciar = 1'b0;
    digito_valido = 1'b0;
    digito_A = 4'h0;
    digito_B = 4'h0;
    test_reset();
    test_equal();
    test_override();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
